z80_bus_ctrl: RTL and testbench

- Machine-cycle sequencer for the Z80 core's external bus. It is the initiator side of the datapath's control interface.
- Steps through T-states for one requested machine cycle: opcode fetch (OCF), memory read/write, I/O read/write.
- Generates the active-low external bus strobes and the datapath controls that drive the address, drive or capture data, and bump PC.
- Sits between the instruction decoder (which issues cycle requests) and the datapath plus pins.

---
 rtl/z80_bus_ctrl_pkg.sv | 61 ++++++
 rtl/z80_bus_ctrl_if.sv | 44 ++++
 rtl/z80_bus_ctrl.sv | 148 ++++++++++++++
 tb/tb_z80_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_ctrl_pkg.sv
// Shared types for the Z80 machine-cycle sequencer: cycle codes, T-states,
// the external strobe vector and the registered control word.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    OCF  = 3'd0,
    MRD  = 3'd1,
    MWR  = 3'd2,
    IORD = 3'd3,
    IOWR = 3'd4
  } cycle_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5
  } tstate_t;

  typedef struct packed {
    logic m1_l;
    logic mreq_l;
    logic iorq_l;
    logic rd_l;
    logic wr_l;
    logic rfsh_l;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '1;

  // ld_ir_pend is qualified with WAIT_L at the output, since the T2/TW that
  // captures the opcode is only known once the wait decision is made.
  typedef struct packed {
    strobes_t strb;
    logic     drive_mar;
    logic     drive_refresh;
    logic     pc_incr;
    logic     ld_ir_pend;
    logic     ld_mdr1;
    logic     drive_mdr1;
    logic     done;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    strb:          STROBES_IDLE,
    drive_mar:     1'b0,
    drive_refresh: 1'b0,
    pc_incr:       1'b0,
    ld_ir_pend:    1'b0,
    ld_mdr1:       1'b0,
    drive_mdr1:    1'b0,
    done:          1'b0
  };

  function automatic logic is_legal(input logic [2:0] code);
    return code <= 3'd4;
  endfunction

endpackage

// File: rtl/z80_bus_ctrl_if.sv
// Control interface between the bus sequencer (master) and the decoder,
// datapath and pins (slave).
interface z80_bus_ctrl_if
  import z80_bus_pkg::*;
#(
  parameter int TCNT_W = 4
);

  logic              start;
  logic [2:0]        cycle_type;
  logic              WAIT_L;
  logic              ready;
  logic              busy;
  logic              done;
  tstate_t           t_state;
  logic [TCNT_W-1:0] t_count;
  logic              M1_L;
  logic              MREQ_L;
  logic              IORQ_L;
  logic              RD_L;
  logic              WR_L;
  logic              RFSH_L;
  logic              drive_MAR;
  logic              drive_refresh;
  logic              pc_incr;
  logic              ld_IR;
  logic              ld_MDR1;
  logic              drive_MDR1;

  modport master (
    input  start, cycle_type, WAIT_L,
    output ready, busy, done, t_state, t_count,
    output M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L,
    output drive_MAR, drive_refresh, pc_incr, ld_IR, ld_MDR1, drive_MDR1
  );

  modport slave (
    output start, cycle_type, WAIT_L,
    input  ready, busy, done, t_state, t_count,
    input  M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L,
    input  drive_MAR, drive_refresh, pc_incr, ld_IR, ld_MDR1, drive_MDR1
  );

endinterface

// File: rtl/z80_bus_ctrl.sv
// Z80 machine-cycle sequencer: walks T1..T4 (with waits) for one requested
// bus cycle and emits registered strobes and datapath controls.
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter int IO_AUTO_WAIT = 1,
  parameter int TCNT_W       = 4
) (
  input  logic           clk,
  input  logic           rst_L,
  z80_bus_ctrl_if.master bus
);

  localparam logic [2:0] AW_INIT = 3'(IO_AUTO_WAIT);

  tstate_t           state, state_nx;
  cycle_t            cur_type, type_nx;
  logic [2:0]        aw_cnt, aw_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;
  ctl_t              ctl_q, ctl_nx;
  logic              ready;
  logic              accept;

  function automatic ctl_t decode(input tstate_t st, input cycle_t ty);
    ctl_t c;
    c = CTL_IDLE;
    if (st != IDLE) begin
      case (ty)
        OCF: begin
          case (st)
            T1: begin
              c.strb.m1_l = 1'b0; c.strb.mreq_l = 1'b0; c.strb.rd_l = 1'b0;
              c.drive_mar = 1'b1; c.pc_incr = 1'b1;
            end
            T2, TW: begin
              c.strb.m1_l = 1'b0; c.strb.mreq_l = 1'b0; c.strb.rd_l = 1'b0;
              c.drive_mar = 1'b1; c.ld_ir_pend = 1'b1;
            end
            T3: begin
              c.strb.mreq_l = 1'b0; c.strb.rfsh_l = 1'b0;
              c.drive_refresh = 1'b1;
            end
            T4: begin
              c.strb.rfsh_l = 1'b0; c.drive_refresh = 1'b1; c.done = 1'b1;
            end
            default: c = CTL_IDLE;
          endcase
        end
        MRD: begin
          c.strb.mreq_l = 1'b0; c.strb.rd_l = 1'b0; c.drive_mar = 1'b1;
          if (st == T3) begin
            c.ld_mdr1 = 1'b1; c.done = 1'b1;
          end
        end
        MWR: begin
          c.strb.mreq_l = 1'b0; c.drive_mar = 1'b1; c.drive_mdr1 = 1'b1;
          if (st != T1) c.strb.wr_l = 1'b0;
          if (st == T3) c.done = 1'b1;
        end
        IORD, IOWR: begin
          c.drive_mar  = 1'b1;
          c.drive_mdr1 = (ty == IOWR);
          if (st != T1) begin
            c.strb.iorq_l = 1'b0;
            if (ty == IORD) c.strb.rd_l = 1'b0;
            else            c.strb.wr_l = 1'b0;
          end
          if (st == T3) begin
            c.ld_mdr1 = (ty == IORD); c.done = 1'b1;
          end
        end
        default: c = CTL_IDLE;
      endcase
    end
    return c;
  endfunction

  assign ready  = (state == IDLE) || ctl_q.done;
  assign accept = bus.start && ready && is_legal(bus.cycle_type);

  // The auto-wait counter is loaded on entry to T1 and spent in T2/TW
  // before WAIT_L is looked at.
  always_comb begin
    state_nx = state;
    type_nx  = cur_type;
    aw_nx    = aw_cnt;
    if (accept) type_nx = cycle_t'(bus.cycle_type);
    case (state)
      IDLE:   state_nx = accept ? T1 : IDLE;
      T1:     state_nx = T2;
      T2, TW: begin
        if (aw_cnt != 3'd0) begin
          state_nx = TW;
          aw_nx    = aw_cnt - 3'd1;
        end else begin
          state_nx = bus.WAIT_L ? T3 : TW;
        end
      end
      T3:     state_nx = (cur_type == OCF) ? T4 : (accept ? T1 : IDLE);
      T4:     state_nx = accept ? T1 : IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx == T1)
      aw_nx = (type_nx == IORD || type_nx == IOWR) ? AW_INIT : 3'd0;

    if (state_nx == IDLE)    tcnt_nx = '0;
    else if (state_nx == T1) tcnt_nx = TCNT_W'(1);
    else if (&tcnt)          tcnt_nx = tcnt;
    else                     tcnt_nx = tcnt + 1'b1;

    ctl_nx = decode(state_nx, type_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state    <= IDLE;
      cur_type <= OCF;
      aw_cnt   <= 3'd0;
      tcnt     <= '0;
      ctl_q    <= CTL_IDLE;
    end else begin
      state    <= state_nx;
      cur_type <= type_nx;
      aw_cnt   <= aw_nx;
      tcnt     <= tcnt_nx;
      ctl_q    <= ctl_nx;
    end
  end

  assign bus.ready         = ready;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = ctl_q.done;
  assign bus.t_state       = state;
  assign bus.t_count       = tcnt;
  assign bus.M1_L          = ctl_q.strb.m1_l;
  assign bus.MREQ_L        = ctl_q.strb.mreq_l;
  assign bus.IORQ_L        = ctl_q.strb.iorq_l;
  assign bus.RD_L          = ctl_q.strb.rd_l;
  assign bus.WR_L          = ctl_q.strb.wr_l;
  assign bus.RFSH_L        = ctl_q.strb.rfsh_l;
  assign bus.drive_MAR     = ctl_q.drive_mar;
  assign bus.drive_refresh = ctl_q.drive_refresh;
  assign bus.pc_incr       = ctl_q.pc_incr;
  assign bus.ld_IR         = ctl_q.ld_ir_pend & bus.WAIT_L & (aw_cnt == 3'd0);
  assign bus.ld_MDR1       = ctl_q.ld_mdr1;
  assign bus.drive_MDR1    = ctl_q.drive_mdr1;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Self-checking bench for z80_bus_ctrl: table of machine cycles, hand-written
// corner sequences and random cycles against a phase-timeline model.
module tb_z80_bus_ctrl;
  import z80_bus_pkg::*;

  localparam int AUTO = 1;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  always #5 clk = ~clk;

  z80_bus_ctrl_if #(.TCNT_W(4)) bus ();

  z80_bus_ctrl #(.IO_AUTO_WAIT(AUTO), .TCNT_W(4)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] ts;
    logic [3:0] tc;
    logic [5:0] strb;
    logic dmar, dref, pci, ldir, ldmdr, dmdr, done, busy, ready;
  } obs_t;

  typedef struct {
    logic [2:0] ty;
    int         k;
    int         exp_len;
    string      name;
  } vec_t;

  function automatic obs_t observe();
    obs_t o;
    o.ts    = bus.t_state;
    o.tc    = bus.t_count;
    o.strb  = {bus.M1_L, bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L, bus.RFSH_L};
    o.dmar  = bus.drive_MAR;
    o.dref  = bus.drive_refresh;
    o.pci   = bus.pc_incr;
    o.ldir  = bus.ld_IR;
    o.ldmdr = bus.ld_MDR1;
    o.dmdr  = bus.drive_MDR1;
    o.done  = bus.done;
    o.busy  = bus.busy;
    o.ready = bus.ready;
    return o;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e = '0;
    e.ts    = IDLE;
    e.strb  = 6'h3f;
    e.ready = 1'b1;
    return e;
  endfunction

  // Expected outputs for phase idx of a cycle, straight from the strobe tables.
  function automatic obs_t model(input logic [2:0] ty, input tstate_t ph,
                                 input bit exiting, input int idx);
    obs_t e;
    logic m1, mreq, iorq, rd, wr, rfsh;
    bit   mid;
    e = '0;
    m1 = 1; mreq = 1; iorq = 1; rd = 1; wr = 1; rfsh = 1;
    mid = (ph == T2 || ph == TW);
    e.ts   = ph;
    e.tc   = 4'((idx + 1 > 15) ? 15 : idx + 1);
    e.busy = 1'b1;
    case (ty)
      3'd0: begin
        if (ph == T1 || mid) begin m1 = 0; mreq = 0; rd = 0; e.dmar = 1; end
        e.pci  = (ph == T1);
        e.ldir = mid && exiting;
        if (ph == T3) begin mreq = 0; rfsh = 0; e.dref = 1; end
        if (ph == T4) begin rfsh = 0; e.dref = 1; e.done = 1; end
      end
      3'd1: begin
        mreq = 0; rd = 0; e.dmar = 1;
        if (ph == T3) begin e.ldmdr = 1; e.done = 1; end
      end
      3'd2: begin
        mreq = 0; e.dmar = 1; e.dmdr = 1;
        if (ph != T1) wr = 0;
        if (ph == T3) e.done = 1;
      end
      default: begin
        e.dmar = 1;
        e.dmdr = (ty == 3'd4);
        if (ph != T1) begin
          iorq = 0;
          if (ty == 3'd3) rd = 0; else wr = 0;
        end
        if (ph == T3) begin e.ldmdr = (ty == 3'd3); e.done = 1; end
      end
    endcase
    e.strb  = {m1, mreq, iorq, rd, wr, rfsh};
    e.ready = e.done;
    return e;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = observe();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got ts=%0d tc=%0d strb=%b ctl=%b, expected ts=%0d tc=%0d strb=%b ctl=%b",
               name, act.ts, act.tc, act.strb, act[8:0], exp.ts, exp.tc, exp.strb, exp[8:0]);
    end
  endtask

  // Entered after the negedge of a cycle in which ready=1; returns after the
  // negedge check of the cycle's done phase.
  task automatic run_txn(input logic [2:0] ty, input int k, output int last_tc);
    tstate_t tl[$];
    int      n;
    bit      io;
    io = (ty == 3'd3 || ty == 3'd4);
    n  = (io ? AUTO : 0) + k;
    tl.push_back(T1);
    tl.push_back(T2);
    repeat (n) tl.push_back(TW);
    tl.push_back(T3);
    if (ty == 3'd0) tl.push_back(T4);
    last_tc = -1;
    bus.start      = 1'b1;
    bus.cycle_type = ty;
    @(posedge clk); #1;
    for (int i = 0; i < tl.size(); i++) begin
      bit last;
      last = (i == tl.size() - 1);
      if (i >= 1 && i <= n)
        bus.WAIT_L = (io && i <= AUTO) ? 1'($urandom_range(0, 1)) : 1'b0;
      else if (i == n + 1)
        bus.WAIT_L = 1'b1;
      else
        bus.WAIT_L = 1'($urandom_range(0, 1));
      bus.start      = last ? 1'b0 : 1'($urandom_range(0, 1));
      bus.cycle_type = 3'($urandom_range(0, 7));
      @(negedge clk);
      last_tc = int'(bus.t_count);
      check($sformatf("type%0d_k%0d_ph%0d", ty, k, i), model(ty, tl[i], i == n + 1, i));
      if (!last) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle_cycle(input string name);
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check(name, idle_exp());
  endtask

  vec_t tbl[6];
  int   ltc;

  initial begin
    tbl[0] = '{3'd0, 0, 4, "ocf"};
    tbl[1] = '{3'd1, 3, 6, "mrd_wait3"};
    tbl[2] = '{3'd2, 0, 3, "mwr"};
    tbl[3] = '{3'd3, 0, 4, "iord_auto"};
    tbl[4] = '{3'd4, 1, 5, "iowr_wait1"};
    tbl[5] = '{3'd0, 2, 6, "ocf_wait2"};

    bus.start = 1'b0; bus.cycle_type = 3'd0; bus.WAIT_L = 1'b1;
    rst_L = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", idle_exp());
    rst_L = 1'b1;
    idle_cycle("idle_after_reset");

    for (int v = 0; v < 6; v++) begin
      run_txn(tbl[v].ty, tbl[v].k, ltc);
      n_checks++;
      if (ltc != tbl[v].exp_len) begin
        n_fail++;
        $display("[TB] FAIL len_%s: t_count at done %0d, expected %0d", tbl[v].name, ltc, tbl[v].exp_len);
      end
      idle_cycle($sformatf("idle_after_%s", tbl[v].name));
    end

    // Reset held for two clocks in the middle of a write's T2.
    bus.start = 1'b1; bus.cycle_type = 3'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_mwr_t1", model(3'd2, T1, 1'b0, 0));
    @(posedge clk); #1;
    bus.WAIT_L = 1'b0;
    @(negedge clk);
    check("rst_mwr_t2", model(3'd2, T2, 1'b0, 1));
    rst_L = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_1", idle_exp());
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_2", idle_exp());
    rst_L = 1'b1; bus.WAIT_L = 1'b1;
    idle_cycle("idle_after_rst_mid");

    bus.start = 1'b1; bus.cycle_type = 3'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("illegal6_from_idle", idle_exp());

    run_txn(3'd1, 0, ltc);
    bus.start = 1'b1; bus.cycle_type = 3'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("illegal7_at_done", idle_exp());

    run_txn(3'd1, 0, ltc);
    run_txn(3'd2, 0, ltc);
    idle_cycle("idle_after_b2b");

    for (int r = 0; r < 40; r++) begin
      run_txn(3'($urandom_range(0, 4)), int'($urandom_range(0, 3)), ltc);
      if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rand_idle_%0d", r));
    end
    idle_cycle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
